cache_fill_fsm: RTL

Miss-handling controller for one cache (I or D) in front of the shared multicycle memory.
- On a cache miss it requests the memory port from the cache-to-memory arbiter.
- Once granted, it streams the 8 word-read addresses of the missed block into the pipelined memory.
- It counts returning words into the cache data array, then writes the tag.
- Two instances are used, one per cache; they sit between the cache arrays and the arbiter.

---
 rtl/cache_fill_fsm_pkg.sv | 17 +
 rtl/cache_fill_fsm_fill_counter.sv | 25 ++
 rtl/cache_fill_fsm.sv | 112 +++++++++++
 3 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants and state encoding for the cache miss-fill controller.
// Block geometry, word stride and FSM states live here.
package cache_fill_fsm_pkg;

  localparam int MEM_ADDR_W  = 16;
  localparam int BLK_WORDS   = 8;
  localparam int BLK_CNT_W   = 3;
  localparam int BLK_OFF_W   = BLK_CNT_W + 1;
  localparam int WORD_STRIDE = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WAIT_GRANT = 2'b01,
    FILL       = 2'b10
  } fill_state_t;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for a block fill: sync clear, enable, and a
// saturation flag once the full block has been counted.
module fill_counter #(
  parameter int W   = 4,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = (cnt == W'(MAX));

  // Count up until the block is complete, then hold.
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && !sat)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: arbitrates for memory, streams a block of
// word reads, writes returning words and finally the tag.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_W          = MEM_ADDR_W,
  parameter int WORDS_PER_BLOCK = BLK_WORDS,
  parameter int CNT_W           = BLK_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_grant,
  output logic              mem_req,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] memory_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic              fsm_busy,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] cache_word_addr,
  output logic [15:0]       cache_data,
  output logic              write_tag_array,
  output logic              fill_done
);

  localparam int OFF_W = CNT_W + 1;

  fill_state_t       state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W:0]    issue_cnt;
  logic [CNT_W:0]    recv_cnt;
  logic              issue_sat;
  logic              recv_sat;
  logic              grant_hit;
  logic              in_fill;
  logic              last;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] recv_addr;

  assign grant_hit = (state == WAIT_GRANT) && mem_grant;
  assign in_fill   = (state == FILL) && !rst;

  fill_counter #(
    .W   (CNT_W + 1),
    .MAX (WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (grant_hit),
    .inc (mem_enable),
    .cnt (issue_cnt),
    .sat (issue_sat)
  );

  fill_counter #(
    .W   (CNT_W + 1),
    .MAX (WORDS_PER_BLOCK)
  ) u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (grant_hit),
    .inc (write_data_array),
    .cnt (recv_cnt),
    .sat (recv_sat)
  );

  assign issue_addr = base
    + ADDR_W'(WORD_STRIDE) * ADDR_W'(issue_cnt);
  assign recv_addr  = base
    + ADDR_W'(WORD_STRIDE) * ADDR_W'(recv_cnt);

  assign mem_req          = (state != IDLE) && !rst;
  assign fsm_busy         = mem_req;
  assign mem_enable       = in_fill && !issue_sat;
  assign memory_address   = mem_enable ? issue_addr : '0;
  assign write_data_array = in_fill && memory_data_valid && !recv_sat;
  assign cache_word_addr  = write_data_array ? recv_addr : '0;
  assign cache_data       = memory_data;
  assign last             = write_data_array
    && (recv_cnt == (CNT_W + 1)'(WORDS_PER_BLOCK - 1));
  assign write_tag_array  = last;
  assign fill_done        = last;

  // State and block base; the fill ends on the last returned word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss_detected) begin
            base  <= {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            state <= WAIT_GRANT;
          end
        end
        WAIT_GRANT: begin
          if (mem_grant)
            state <= FILL;
        end
        FILL: begin
          if (last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
